// File: rtl/bali_loader_pkg.sv
// rtl/bali_loader_pkg.sv - shared types and constants for the program loader
//
// Purpose: loader FSM state encoding, error codes and the default frame
// start marker used by prog_loader and its benches.
package bali_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_COMMIT,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CHK  = 2'b10
  } loader_err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB4;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader into CPU program memory
//
// Purpose: accepts SYNC, LEN_HI, LEN_LO, LEN payload bytes, CHK over a
// valid/ready byte port, writes the payload to program memory from address 0
// and holds the CPU in reset until the XOR checksum of the frame matches.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   upstream byte handshake, in_data the byte
//   mem_we/mem_addr/mem_wdata  program memory write port (1-cycle latency)
//   cpu_hold            1 keeps the CPU in reset
//   done                valid image loaded, CPU released
//   error               00 none, 01 bad length, 10 checksum mismatch
module prog_loader
  import bali_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [1:0]            error
);

  // Counter is one bit wider than the address so a full-capacity image
  // (LEN == 2**ADDR_WIDTH) can be counted to completion without wrapping.
  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  loader_state_t   state_q, state_d;
  loader_err_t     err_q;
  logic [7:0]      len_hi_q;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_next;
  logic [7:0]      acc_q;
  logic            match_q;
  logic            xfer;
  logic            is_sync;
  logic [15:0]     len_word;
  logic            len_bad;

  assign in_ready = rst && (state_q != ST_COMMIT);
  assign xfer     = in_valid && in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign len_word = {len_hi_q, in_data};
  assign len_bad  = (len_word == 16'd0) || ({1'b0, len_word} > CAPACITY);
  assign cnt_next = cnt_q + CW'(1);
  assign error    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer && is_sync) state_d = ST_LEN_HI;
      ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
      ST_LEN_LO: if (xfer) state_d = len_bad ? ST_ERROR : ST_DATA;
      ST_DATA:   if (xfer && (cnt_next == len_q)) state_d = ST_CHECK;
      ST_CHECK:  if (xfer) state_d = ST_COMMIT;
      ST_COMMIT: state_d = match_q ? ST_RUN : ST_ERROR;
      ST_RUN,
      ST_ERROR:  if (xfer && is_sync) state_d = ST_LEN_HI;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err_q     <= ERR_NONE;
      len_hi_q  <= 8'h00;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= 8'h00;
      match_q   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        ST_LEN_HI: if (xfer) len_hi_q <= in_data;
        ST_LEN_LO: begin
          if (xfer) begin
            if (len_bad) begin
              err_q <= ERR_LEN;
            end else begin
              len_q <= len_word[CW-1:0];
              cnt_q <= '0;
              acc_q <= 8'h00;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_q[ADDR_WIDTH-1:0];
            mem_wdata <= in_data;
            cnt_q     <= cnt_next;
            acc_q     <= acc_q ^ in_data;
          end
        end
        ST_CHECK: if (xfer) match_q <= (in_data == acc_q);
        ST_COMMIT: begin
          if (match_q) begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            err_q <= ERR_CHK;
          end
        end
        ST_RUN,
        ST_ERROR: begin
          // A new SYNC re-arms the hold before any new payload is written.
          if (xfer && is_sync) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err_q    <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;
  import bali_loader_pkg::*;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic [1:0]    error;

  prog_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hB4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] payload[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat ($urandom_range(0, gap)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
  endtask

  function automatic logic [7:0] xor_of(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= payload[i];
    return x;
  endfunction

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  // Reference: a legal length writes payload[i] at address i; the image is
  // accepted only when CHK equals the XOR of the payload.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] chk, input int gap);
    bit         legal;
    logic [7:0] x;
    legal = (len != 16'd0) && (int'(len) <= CAP);
    send_byte(8'hB4, gap);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    if (!legal) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("len_err_error", 32'(error), 32'h1);
      check("len_err_hold", 32'(cpu_hold), 32'h1);
      check("len_err_done", 32'(done), 32'h0);
      check("len_err_ready", 32'(in_ready), 32'h1);
      return;
    end
    x = xor_of(int'(len));
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back('{addr: AW'(i), data: payload[i]});
      send_byte(payload[i], gap);
    end
    send_byte(chk, gap);
    @(negedge clk);
    in_valid = 1'b0;
    check("commit_ready", 32'(in_ready), 32'h0);
    check("commit_done", 32'(done), 32'h0);
    check("commit_hold", 32'(cpu_hold), 32'h1);
    @(negedge clk);
    check("post_done", 32'(done), (chk == x) ? 32'h1 : 32'h0);
    check("post_hold", 32'(cpu_hold), (chk == x) ? 32'h0 : 32'h1);
    check("post_error", 32'(error), (chk == x) ? 32'h0 : 32'h2);
    check("post_ready", 32'(in_ready), 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'h0);
    check({tag, "_we"}, 32'(mem_we), 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'h1);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic 3-byte image.
    payload = '{8'h10, 8'h20, 8'h30};
    run_frame(16'd3, 8'h00, 0);

    // Leading garbage then a 1-byte image.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    payload = '{8'hAA};
    run_frame(16'd1, 8'hAA, 0);

    // Checksum mismatch, then recovery with a good frame.
    payload = '{8'h11, 8'h22};
    run_frame(16'd2, 8'h00, 0);
    fill_random(7);
    run_frame(16'd7, xor_of(7), 1);

    // Length too large, then full-capacity image.
    run_frame(16'h0401, 8'h00, 0);
    fill_random(CAP);
    run_frame(16'(CAP), xor_of(CAP), 0);

    // Random gaps on a 5-byte image.
    fill_random(5);
    run_frame(16'd5, xor_of(5), 4);

    // Reset after two payload bytes.
    fill_random(5);
    send_byte(8'hB4, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: AW'(i), data: payload[i]});
      send_byte(payload[i], 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("midrst");
    check("midrst_queue", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    fill_random(4);
    run_frame(16'd4, xor_of(4), 1);

    // Random frames, some corrupted.
    for (int f = 0; f < 8; f++) begin
      int n;
      logic [7:0] c;
      n = $urandom_range(1, 40);
      fill_random(n);
      c = xor_of(n);
      if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
      run_frame(16'(n), c, 2);
    end

    repeat (3) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
